// File: rtl/video_timing_monitor.sv
// video_timing_monitor: measures line/frame timing of a pixel stream and flags lock
// once identical measurements repeat for LOCK_FRAMES frames.
module video_timing_monitor #(
  parameter int HW            = 12,
  parameter int VW            = 11,
  parameter int LOCK_FRAMES   = 4,
  parameter bit HS_ACTIVE_LOW = 1'b1,
  parameter bit VS_ACTIVE_LOW = 1'b0
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          ce_pix_i,
  input  logic          h_blank_i,
  input  logic          v_blank_i,
  input  logic          h_sync_i,
  input  logic          v_sync_i,
  output logic [HW-1:0] htotal_o,
  output logic [HW-1:0] hactive_o,
  output logic [HW-1:0] hsync_w_o,
  output logic [VW-1:0] vtotal_o,
  output logic [VW-1:0] vactive_o,
  output logic [VW-1:0] vsync_w_o,
  output logic          frame_stb_o,
  output logic          valid_o,
  output logic          locked_o
);
  typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;
  state_t        state_q;
  logic          hb_q, vb_q, pend_q, stb_q, valid_q, locked_q, same;
  logic          hs_a, vs_a, line_start, frame_start, loss;
  logic [3:0]    stable_q, stable_d;
  logic [HW-1:0] hc_q, ha_q, hs_q, hc_d, ha_d, hs_d, lt_q, la_q, lh_q, ht_q, hact_q, hsw_q;
  logic [VW-1:0] vc_q, va_q, vs_q, vc_d, va_d, vs_d, fc_q, fa_q, fs_q, vt_q, vact_q, vsw_q;

  function automatic logic [HW-1:0] hinc(input logic [HW-1:0] a, input logic b);
    return (&a) ? a : a + HW'(b);
  endfunction

  function automatic logic [VW-1:0] vinc(input logic [VW-1:0] a, input logic b);
    return (&a) ? a : a + VW'(b);
  endfunction

  assign hs_a        = h_sync_i ^ HS_ACTIVE_LOW;
  assign vs_a        = v_sync_i ^ VS_ACTIVE_LOW;
  assign line_start  = ce_pix_i & ~h_blank_i & hb_q;
  assign frame_start = ce_pix_i & ~v_blank_i & vb_q;
  // a line that never ends means the source is gone
  assign loss        = &hc_q;

  always_comb begin
    hc_d     = line_start ? HW'(1) : hinc(hc_q, 1'b1);
    ha_d     = line_start ? HW'(1) : hinc(ha_q, ~h_blank_i);
    hs_d     = line_start ? HW'(hs_a) : hinc(hs_q, hs_a);
    vc_d     = frame_start ? VW'(line_start) : vinc(vc_q, line_start);
    va_d     = frame_start ? VW'(line_start & ~v_blank_i) : vinc(va_q, line_start & ~v_blank_i);
    vs_d     = frame_start ? VW'(line_start & vs_a) : vinc(vs_q, line_start & vs_a);
    same     = valid_q && ({ht_q, hact_q, hsw_q, vt_q, vact_q, vsw_q} ==
                           {lt_q, la_q, lh_q, fc_q, fa_q, fs_q});
    stable_d = !same ? 4'd0 : (stable_q == 4'(LOCK_FRAMES)) ? stable_q : stable_q + 4'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      {hb_q, vb_q, pend_q, stb_q, valid_q, locked_q} <= '0;
      stable_q <= '0;
      {hc_q, ha_q, hs_q, lt_q, la_q, lh_q, ht_q, hact_q, hsw_q} <= '0;
      {vc_q, va_q, vs_q, fc_q, fa_q, fs_q, vt_q, vact_q, vsw_q} <= '0;
    end else if (loss) begin
      state_q  <= IDLE;
      {pend_q, stb_q, valid_q, locked_q} <= '0;
      stable_q <= '0;
      {hc_q, ha_q, hs_q, lt_q, la_q, lh_q} <= '0;
      {vc_q, va_q, vs_q, fc_q, fa_q, fs_q} <= '0;
    end else begin
      stb_q  <= pend_q;
      pend_q <= frame_start && state_q != IDLE;
      if (pend_q) begin
        {ht_q, hact_q, hsw_q} <= {lt_q, la_q, lh_q};
        {vt_q, vact_q, vsw_q} <= {fc_q, fa_q, fs_q};
        valid_q  <= 1'b1;
        stable_q <= stable_d;
        locked_q <= stable_d == 4'(LOCK_FRAMES);
      end
      if (ce_pix_i) begin
        hb_q <= h_blank_i;
        vb_q <= v_blank_i;
        {hc_q, ha_q, hs_q} <= {hc_d, ha_d, hs_d};
        {vc_q, va_q, vs_q} <= {vc_d, va_d, vs_d};
      end
      if (line_start) {lt_q, la_q, lh_q} <= {hc_q, ha_q, hs_q};
      if (frame_start) begin
        {fc_q, fa_q, fs_q} <= {vc_q, va_q, vs_q};
        state_q <= (state_q == IDLE) ? SYNC : TRACK;
      end
    end
  end

  assign htotal_o    = ht_q;
  assign hactive_o   = hact_q;
  assign hsync_w_o   = hsw_q;
  assign vtotal_o    = vt_q;
  assign vactive_o   = vact_q;
  assign vsync_w_o   = vsw_q;
  assign frame_stb_o = stb_q;
  assign valid_o     = valid_q;
  assign locked_o    = locked_q;
endmodule

// File: tb/tb_video_timing_monitor.sv
// tb_video_timing_monitor: raster generator drives the monitor; expected loads are queued
// before each frame and popped whenever frame_stb fires.
module tb_video_timing_monitor;
  localparam int HW = 12;
  localparam int VW = 11;
  logic          clk = 1'b0, reset = 1'b0, ce = 1'b0;
  logic          hb = 1'b1, vb = 1'b1, hs = 1'b1, vs = 1'b0;
  logic [HW-1:0] htotal, hactive, hsync_w;
  logic [VW-1:0] vtotal, vactive, vsync_w;
  logic          frame_stb, valid, locked;
  int            n_tests = 0, n_fail = 0, ce_per = 4;
  int            g_ht, g_ha, g_hs, g_vt, g_va, g_vs, g_vbx;
  typedef struct {int ht; int ha; int hsw; int vt; int va; int vsw; bit lk;} exp_t;
  exp_t          sb[$];

  video_timing_monitor #(.HW(HW), .VW(VW), .LOCK_FRAMES(4), .HS_ACTIVE_LOW(1'b1),
                         .VS_ACTIVE_LOW(1'b0)) dut (
    .clk_i(clk), .reset_i(reset), .ce_pix_i(ce), .h_blank_i(hb), .v_blank_i(vb),
    .h_sync_i(hs), .v_sync_i(vs), .htotal_o(htotal), .hactive_o(hactive), .hsync_w_o(hsync_w),
    .vtotal_o(vtotal), .vactive_o(vactive), .vsync_w_o(vsync_w), .frame_stb_o(frame_stb),
    .valid_o(valid), .locked_o(locked));

  always #5 clk = ~clk;

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (frame_stb) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stb_unexpected: frame_stb=1 got, no load expected");
      end else begin
        e = sb.pop_front();
        if (htotal !== 12'(e.ht) || hactive !== 12'(e.ha) || hsync_w !== 12'(e.hsw) ||
            vtotal !== 11'(e.vt) || vactive !== 11'(e.va) || vsync_w !== 11'(e.vsw) ||
            valid !== 1'b1 || locked !== e.lk) begin
          n_fail++;
          $display("FAIL load: got %0d/%0d/%0d %0d/%0d/%0d v%0b l%0b want %0d/%0d/%0d %0d/%0d/%0d v1 l%0b",
                   htotal, hactive, hsync_w, vtotal, vactive, vsync_w, valid, locked,
                   e.ht, e.ha, e.hsw, e.vt, e.va, e.vsw, e.lk);
        end
      end
    end
  endtask

  task automatic sample(bit h_b, bit v_b, bit h_s, bit v_s);
    ce = 1'b1; hb = h_b; vb = v_b; hs = ~h_s; vs = v_s;
    tick();
    ce = 1'b0;
    repeat (ce_per - 1) tick();
  endtask

  // v_blank/v_sync follow the next line once x passes g_vbx (0: change at line start)
  task automatic pix(int y, int x, int vt_cur);
    int yy;
    yy = (g_vbx != 0 && x >= g_vbx) ? y + 1 : y;
    sample(x >= g_ha, !(yy < g_va || yy == vt_cur), x >= g_ha + 1 && x < g_ha + 1 + g_hs,
           yy >= g_va && yy < g_va + g_vs);
  endtask

  task automatic frame(int vt_cur);
    for (int y = 0; y < vt_cur; y++)
      for (int x = 0; x < g_ht; x++) pix(y, x, vt_cur);
  endtask

  task automatic push(int vt_cur, bit lk);
    exp_t e;
    e.ht = g_ht; e.ha = g_ha; e.hsw = g_hs; e.vt = vt_cur; e.va = g_va; e.vsw = g_vs; e.lk = lk;
    sb.push_back(e);
  endtask

  task automatic drain(string name);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_stb: got %0d loads pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  // reduced raster keeping the 240p shape so each frame stays short
  task automatic set_240p();
    g_ht = 25; g_ha = 20; g_hs = 3; g_vt = 14; g_va = 12; g_vs = 2; g_vbx = 22; ce_per = 4;
  endtask

  task automatic check_zero(string name);
    n_tests++;
    if ({htotal, hactive, hsync_w, vtotal, vactive, vsync_w} !== '0 ||
        {frame_stb, valid, locked} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s: got %0d/%0d/%0d %0d/%0d/%0d s%0b v%0b l%0b want all 0", name,
               htotal, hactive, hsync_w, vtotal, vactive, vsync_w, frame_stb, valid, locked);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check_zero("reset_outputs");
  endtask

  task automatic test_lock();
    set_240p();
    repeat (4) sample(1, 1, 0, 0);
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL lock_pre_valid: got %0b want 0", valid); end
    for (int i = 0; i < 6; i++) begin
      push(g_vt, i >= 4);
      frame(g_vt);
    end
    drain("lock");
  endtask

  task automatic test_change();
    push(g_vt + 1, 1'b0);
    frame(g_vt + 1);
    push(g_vt, 1'b0);
    frame(g_vt);
    for (int i = 0; i < 4; i++) begin
      push(g_vt, i == 3);
      frame(g_vt);
    end
    drain("change");
    n_tests++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL change_relock: got %0b want 1", locked); end
  endtask

  task automatic test_async_reset();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < (y == 2 ? 10 : g_ht); x++) pix(y, x, g_vt);
    #2 reset = 1'b1;
    #1 check_zero("async_reset_outputs");
    #2 reset = 1'b0;
    repeat (4) sample(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      push(g_vt, 1'b0);
      frame(g_vt);
    end
    drain("async_recover");
    n_tests++;
    if (valid !== 1'b1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL async_recover_flags: got v%0b l%0b want v1 l0", valid, locked);
    end
  endtask

  task automatic test_loss();
    for (int i = 0; i < 3; i++) begin
      push(g_vt, i == 2);
      frame(g_vt);
    end
    drain("loss_prelock");
    ce_per = 1;
    repeat (4000) sample(1, 1, 0, 0);
    n_tests++;
    if (valid !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_early: got v%0b l%0b want v1 l1", valid, locked);
    end
    repeat (100) sample(1, 1, 0, 0);
    n_tests++;
    if (valid !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_detect: got v%0b l%0b want v0 l0", valid, locked);
    end
    ce_per = 4;
    for (int i = 0; i < 3; i++) begin
      push(g_vt, 1'b0);
      frame(g_vt);
    end
    drain("loss_restart");
  endtask

  task automatic test_coincident();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    g_ht = 100; g_ha = 80; g_hs = 8; g_vt = 50; g_va = 40; g_vs = 3; g_vbx = 0; ce_per = 1;
    repeat (4) sample(1, 1, 0, 0);
    push(g_vt, 1'b0);
    push(g_vt, 1'b0);
    for (int i = 0; i < 3; i++) frame(g_vt);
    drain("coincident");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_change();
    test_async_reset();
    test_loss();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
